// File: rtl/bch_pkg.sv
// Shared types and defaults for the BCH encode/inject/decode path.
package bch_pkg;

  typedef enum logic [1:0] {
    INJ_BYPASS  = 2'd0,
    INJ_FIXED   = 2'd1,
    INJ_BURST   = 2'd2,
    INJ_RANDCNT = 2'd3
  } inj_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAW_CNT = 3'd1,
    ST_DRAW_IDX = 3'd2,
    ST_BURST    = 3'd3,
    ST_OUT      = 3'd4
  } inj_state_t;

  localparam int BCH_N       = 15;
  localparam int BCH_MAX_ERR = 4;

endpackage

// File: rtl/bch_error_injector.sv
// Channel-error injector: flips a PRNG-chosen set of codeword bits between
// the BCH encoder and decoder, with fixed, burst and random-count modes.
module bch_error_injector
  import bch_pkg::*;
#(
  parameter int N       = BCH_N,
  parameter int MAX_ERR = BCH_MAX_ERR,
  parameter int RND_W   = 16,
  localparam int IDX_W  = $clog2(N),
  localparam int CNT_W  = $clog2(MAX_ERR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_err,
  output logic             rnd_req,
  input  logic             rnd_valid,
  input  logic [RND_W-1:0] rnd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [N-1:0]     out_mask,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic             busy
);

  if (N < 2)            $error("bch_error_injector: N must be >= 2");
  if (MAX_ERR > N)      $error("bch_error_injector: MAX_ERR must not exceed N");
  if (RND_W < IDX_W)    $error("bch_error_injector: RND_W must be >= IDX_W");
  if (RND_W < 8)        $error("bch_error_injector: RND_W must be >= 8 for count draws");

  inj_state_t       state, state_n;
  inj_mode_t        mode_q;
  logic [N-1:0]     data, mask, mask_n;
  logic [CNT_W-1:0] cnt, cnt_n, k, k_n, k_inc;
  logic [IDX_W-1:0] start, start_n, idx;
  logic [IDX_W:0]   sum, pos;
  logic [CNT_W-1:0] cnt_req, rnd_cnt;
  logic             idx_ok;
  logic             unused_rnd;

  assign unused_rnd = ^rnd_data;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  assign cnt_req = (int'(num_err) > MAX_ERR) ? CNT_W'(MAX_ERR) : num_err;
  assign rnd_cnt = CNT_W'(int'(rnd_data[7:0]) % (MAX_ERR + 1));
  assign idx     = rnd_data[IDX_W-1:0];
  assign idx_ok  = int'(idx) < N;
  assign k_inc   = k + CNT_W'(1);

  // Burst position wraps with a single compare-subtract: start < N and k < N.
  assign sum = {1'b0, start} + (IDX_W+1)'(k);
  assign pos = (int'(sum) >= N) ? sum - (IDX_W+1)'(N) : sum;

  always_comb begin
    state_n = state;
    mask_n  = mask;
    cnt_n   = cnt;
    k_n     = k;
    start_n = start;
    rnd_req = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          mask_n  = '0;
          k_n     = '0;
          start_n = '0;
          cnt_n   = cnt_req;
          if (mode == INJ_RANDCNT)                      state_n = ST_DRAW_CNT;
          else if (mode == INJ_BYPASS || cnt_req == '0) state_n = ST_OUT;
          else                                          state_n = ST_DRAW_IDX;
        end
      end
      ST_DRAW_CNT: begin
        rnd_req = 1'b1;
        if (rnd_valid) begin
          cnt_n   = rnd_cnt;
          state_n = (rnd_cnt == '0) ? ST_OUT : ST_DRAW_IDX;
        end
      end
      ST_DRAW_IDX: begin
        rnd_req = 1'b1;
        if (rnd_valid && idx_ok) begin
          if (mode_q == INJ_BURST) begin
            start_n     = idx;
            mask_n[idx] = 1'b1;
            k_n         = CNT_W'(1);
            state_n     = (cnt == CNT_W'(1)) ? ST_OUT : ST_BURST;
          end else if (!mask[idx]) begin
            // Already-set positions are rejected so the count stays exact.
            mask_n[idx] = 1'b1;
            k_n         = k_inc;
            if (k_inc == cnt) state_n = ST_OUT;
          end
        end
      end
      ST_BURST: begin
        mask_n[pos[IDX_W-1:0]] = 1'b1;
        k_n                    = k_inc;
        if (k_inc == cnt) state_n = ST_OUT;
      end
      ST_OUT: begin
        if (out_valid && out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= INJ_BYPASS;
      data   <= '0;
      mask   <= '0;
      cnt    <= '0;
      k      <= '0;
      start  <= '0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      cnt   <= cnt_n;
      k     <= k_n;
      start <= start_n;
      if (state == ST_IDLE && in_valid) begin
        data   <= in_data;
        mode_q <= inj_mode_t'(mode);
      end
    end
  end

  // Result registers load once on entering OUT and hold through backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_mask    <= '0;
      out_err_cnt <= '0;
    end else if (state == ST_OUT && !out_valid) begin
      out_valid   <= 1'b1;
      out_data    <= data ^ mask;
      out_mask    <= mask;
      out_err_cnt <= k;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/bch_error_injector.md
Name: bch_error_injector

Overview:
- Parametrised channel-error injector placed between the BCH encoder and the BCH decoder.
- Takes one N-bit codeword over a valid/ready handshake and returns it with a set of error bits flipped.
- Error positions come from an external PRNG stream (gng_ctg-style) using rejection sampling.
- Replaces the fixed 13-bit, fixed-count injector. Adds configurable width, distinct-position guarantee, burst mode, random-count mode, and backpressure.

Parameters:
- N, 15, codeword width in bits; must be >= 2.
- MAX_ERR, 4, maximum errors per word; elaboration error if MAX_ERR > N.
- RND_W, 16, width of the PRNG sample; must be >= IDX_W.
- IDX_W, $clog2(N), derived; bit-position index width.
- CNT_W, $clog2(MAX_ERR+1), derived; error-count width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input codeword valid
- in_ready  out  1  block can accept a codeword
- in_data  in  N  codeword
- mode  in  2  injection mode, sampled at input handshake
- num_err  in  CNT_W  requested error count, sampled at input handshake
- rnd_req  out  1  PRNG enable (drives ce)
- rnd_valid  in  1  PRNG sample valid
- rnd_data  in  RND_W  PRNG sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  N  in_data XOR out_mask
- out_mask  out  N  flipped-bit mask
- out_err_cnt  out  CNT_W  number of bits flipped (popcount of out_mask)
- busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=1; out_valid=0; rnd_req=0; busy=0; out_data, out_mask, out_err_cnt all 0. Internal state=IDLE; mask, count and k all 0.
- Modes:
  - 0 BYPASS: no errors.
  - 1 FIXED: cnt distinct random positions.
  - 2 BURST: cnt contiguous positions starting at a random index, cyclic (wraps modulo N).
  - 3 RANDCNT: cnt = rnd_data[7:0] % (MAX_ERR+1), then the same as FIXED.
- Count clamp: cnt = min(num_err, MAX_ERR). Example: num_err=7 with MAX_ERR=4 gives cnt=4.
- States: IDLE, DRAW_CNT, DRAW_IDX, BURST, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch in_data, mode and cnt; clear the mask.
  - Next state: mode 3 -> DRAW_CNT; mode 0 or cnt==0 -> OUT; otherwise -> DRAW_IDX.
- Sample consumption: a sample is consumed only in a cycle with rnd_req && rnd_valid. rnd_req=1 only in DRAW_CNT and DRAW_IDX.
- DRAW_CNT: consume one sample and set cnt. If the result is 0 -> OUT; otherwise -> DRAW_IDX.
- DRAW_IDX:
  - idx = rnd_data[IDX_W-1:0].
  - Reject (no state change) if idx >= N.
  - FIXED/RANDCNT: also reject if mask[idx]==1. Otherwise set mask[idx] and increment k; when k reaches cnt -> OUT.
  - BURST: the first accepted idx becomes start; set mask[start], set k=1, go to BURST (or OUT if cnt==1).
- BURST: each cycle set mask[(start+k) mod N] and increment k; when k==cnt -> OUT. Wrap uses a compare-subtract, no divider.
- OUT:
  - Registered out_valid=1; out_data, out_mask and out_err_cnt are stable until out_valid && out_ready.
  - On that handshake: -> IDLE; out_valid falls next cycle; in_ready returns to 1 in that same cycle.
- Latency:
  - Bypass: out_valid asserts 2 cycles after the input handshake.
  - FIXED: 1 + (accepted plus rejected samples) + 1 cycles.
- Backpressure: outputs hold indefinitely while out_ready=0, with in_ready=0 and rnd_req=0.
- rnd_valid=0: the FSM stalls in its draw state with no timeout.
- Async reset mid-operation: immediately returns everything to reset values. The partial mask is discarded and no sample is counted.
- in_valid while not in IDLE: ignored; in_ready=0.

Decomposition:
- Shared package bch_pkg holds:
  - inj_mode_t enum {INJ_BYPASS, INJ_FIXED, INJ_BURST, INJ_RANDCNT}.
  - inj_state_t enum.
  - Default constants BCH_N=15 and BCH_MAX_ERR=4.
- No sub-module: a single FSM module. The PRNG is instantiated outside it, at top level.

Test Plan:
- All tests use N=15, MAX_ERR=4.
- Mode 0, in_data=15'h2AAA, out_ready=1 -> out_data=15'h2AAA, mask 0, cnt 0, out_valid 2 cycles after handshake, rnd_req never high.
- Mode 1, num_err=3, samples idx 5, 15, 5, 0, 14 (15 rejected as >=N, second 5 rejected as duplicate) -> mask=15'h4021, out_err_cnt=3, out_data=in_data^15'h4021.
- Mode 2, num_err=4, first sample idx 13 -> mask=15'h6003 (bits 13, 14, 0, 1), exactly one sample consumed.
- Mode 3, rnd_data=16'h0007 (cnt=2), then idx 3, 9 -> mask=15'h0208, out_err_cnt=2. Second case: rnd_data=16'h000A (cnt=0) -> mask 0.
- Mode 1, num_err=7 -> clamped, out_err_cnt=4. Also hold out_ready=0 for 10 cycles -> out_* stable, in_ready=0, rnd_req=0.
- rst pulsed while in DRAW_IDX with rnd_valid held low -> all outputs return to reset values immediately. The next word in mode 0 passes unchanged with mask 0.
